mips_single_cycle_core: RTL and testbench
=========================================

// Module: mips_single_cycle_core
// PURPOSE
//  32-bit MIPS-subset single-cycle processor: one instruction per CLK rising edge.
//  Contains the PC, instruction ROM, 32x32 register file, ALU, byte-addressed data RAM and control decode.
//  Sits under the board top level; CLK is the debounced single-step button clock.
//  All internal datapath nodes are exported for the 7-segment debug display.
// PARAMETERS
//  IMEM_DEPTH  64          instruction ROM size in 32-bit words
//  DMEM_DEPTH  128         data RAM size in bytes
//  IMEM_FILE   "imem.mem"  $readmemb binary image loaded into ROM at elaboration
// PORTS
//  CLK          in   1   CPU clock; all state updates on rising edge
//  Reset        in   1   synchronous, active-high reset
//  cur_PC       out  32  current PC register
//  new_PCaddr   out  32  next-PC value (combinational)
//  ALU_Res      out  32  ALU result
//  Write_Data   out  32  register write-back data (ALU_Res, or DataOut for lw)
//  Data_rs      out  32  register file read port A, rs = Instruction[25:21]
//  Data_rt      out  32  register file read port B, rt = Instruction[20:16]
//  Instruction  out  32  ROM word at cur_PC
//  DataOut      out  32  data RAM read word at ALU_Res
//  Write_Reg    out  5   destination register: rd (R-type), rt (I-type)
// BEHAVIOUR
//  - Reset=1 at rising edge: PC<=0; all 32 registers <=0; data RAM cleared to 0. Reset beats every other action.
//  - Outputs are combinational from state; a reset edge is followed by cur_PC=0 and Data_rs=Data_rt=0.
//  - Fetch: word index cur_PC[31:2]. An index >= IMEM_DEPTH returns 0x00000000 (NOP).
//  - R-type ops (opcode 000000), keyed by funct:
//    add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), sll 000000 (rt<<shamt[10:6]).
//  - I-type ops, keyed by opcode:
//    addiu 001001, slti 001010 (both sign-extended imm);
//    andi 001100, ori 001101, xori 001110 (zero-extended imm);
//    lw 100011, sw 101011 (addr = rs + sext(imm));
//    beq 000100, bne 000101; j 000010.
//  - Unknown opcode or funct: no register/RAM write; PC advances by 4.
//  - Arithmetic is modulo 2^32; no overflow traps.
//  - Next PC:
//    beq taken when Data_rs==Data_rt, bne taken when they differ -> PC+4+(sext(imm)<<2).
//    j -> {PC+4[31:28], Instruction[25:0], 2'b00}. Otherwise PC+4.
//  - Branch compare uses the ALU subtract; ALU_Res shows rs-rt during branches.
//  - Register file: combinational reads, write on rising edge when RegWrite.
//    $0 always reads 0; writes to it are discarded.
//    Read of the register being written this cycle returns the old value.
//  - Data RAM: big-endian words, address taken modulo DMEM_DEPTH with [1:0] forced to 0.
//    Combinational read; write on rising edge for sw (data = Data_rt).
//    Write_Reg, Write_Data and DataOut are always driven, even when nothing is written.
// CONFIGURATION
//  SCPU_HALT_EN defined: opcode 111111 is halt.
//    new_PCaddr = cur_PC, no writes; the core stays frozen until Reset.
//  SCPU_HALT_EN undefined: opcode 111111 is an unknown opcode (NOP, PC+4).
// TESTING
//  1 Reset=1 for 2 edges mid-program, then 0 -> cur_PC=0, Data_rs=Data_rt=0.
//    new_PCaddr=4 when word 0 is not a branch or jump.
//  2 addiu $1,$0,8; ori $2,$0,2; add $3,$1,$2.
//    -> on add: Write_Reg=3, ALU_Res=Write_Data=0x0000000A.
//  3 sw $3,4($0); lw $4,4($0).
//    -> on lw: ALU_Res=4, DataOut=0x0000000A, Write_Reg=4; $4 reads 0xA afterwards.
//  4 beq $1,$1,-2 at PC 0x10 -> new_PCaddr=0x0C.
//    bne $1,$1,5 -> new_PCaddr=PC+4. j 0x000010 -> new_PCaddr=0x40.
//  5 addiu $0,$0,5 -> $0 still reads 0.
//    sub $5,$0,$1 with $1=1 -> 0xFFFFFFFF.
//    slt $6,$5,$1 -> 1. andi with imm 0xFFFF -> upper half zero.
//  6 Opcode 111111 at PC 0x14, three edges.
//    Macro defined: cur_PC stays 0x14. Macro undefined: cur_PC becomes 0x18.

Source files
------------

// File: rtl/mips_single_cycle_core_if.sv
// Debug bundle of datapath nodes exported by mips_single_cycle_core.
// The core drives it through the master modport. The display logic or a bench reads it through slave.
interface mips_single_cycle_core_if;
    logic [31:0] cur_PC;
    logic [31:0] new_PCaddr;
    logic [31:0] ALU_Res;
    logic [31:0] Write_Data;
    logic [31:0] Data_rs;
    logic [31:0] Data_rt;
    logic [31:0] Instruction;
    logic [31:0] DataOut;
    logic [4:0]  Write_Reg;

    modport master (
        output cur_PC, new_PCaddr, ALU_Res, Write_Data, Data_rs, Data_rt,
               Instruction, DataOut, Write_Reg
    );
    modport slave (
        input  cur_PC, new_PCaddr, ALU_Res, Write_Data, Data_rs, Data_rt,
               Instruction, DataOut, Write_Reg
    );
endinterface

// File: rtl/mips_single_cycle_core.sv
// MIPS-subset single-cycle core. Each rising CLK edge executes one instruction.
// The core contains the PC, the instruction ROM, a 32x32 register file, the ALU, and a
// byte-addressed big-endian data RAM.
// All datapath nodes are exported on the debug interface.
// Optional feature: define SCPU_HALT_EN to make opcode 111111 a halt. A halt freezes the
// core until Reset. Without SCPU_HALT_EN, opcode 111111 decodes as an unknown opcode.
module mips_single_cycle_core #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 128,
    parameter string IMEM_FILE  = "imem.mem"
) (
    input  logic                       CLK,
    input  logic                       Reset,
    mips_single_cycle_core_if.master   dbg
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

`ifdef SCPU_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010,
                           OP_ANDI  = 6'b001100, OP_ORI   = 6'b001101, OP_XORI = 6'b001110,
                           OP_LW    = 6'b100011, OP_SW    = 6'b101011, OP_BEQ  = 6'b000100,
                           OP_BNE   = 6'b000101, OP_J     = 6'b000010, OP_HALT = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR  = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL} alu_op_e;

    logic [31:0] rom [IMEM_DEPTH];
    logic [31:0] regs_q [32];
    logic [7:0]  dmem_q [DMEM_DEPTH];
    logic [31:0] pc_q, pc_d;

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, wr_reg;
    logic [31:0] simm, zimm, rs_data, rt_data, alu_b, alu_res, wr_data, rd_word;
    logic [31:0] pc4, br_tgt;
    logic        reg_we, mem_we, mem_rd, use_imm, imm_zext, is_beq, is_bne, is_jmp, halt, take_br;
    alu_op_e     alu_op;
    logic [DAW-1:0] daddr;

    // Fetch: an out-of-range word index reads as 0, which decodes as a harmless sll $0.
    always_comb begin
        instr = '0;
        if (pc_q[31:2] < 30'(IMEM_DEPTH)) instr = rom[pc_q[IAW+1:2]];
    end

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'h0000, instr[15:0]};

    // Control decode. Unknown encodings keep every write disabled.
    always_comb begin
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        mem_rd   = 1'b0;
        use_imm  = 1'b0;
        imm_zext = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_jmp   = 1'b0;
        halt     = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLL:   alu_op = ALU_SLL;
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDIU: begin reg_we = 1'b1; use_imm = 1'b1; end
            OP_SLTI:  begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
            OP_ANDI:  begin reg_we = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin reg_we = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR; end
            OP_XORI:  begin reg_we = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_XOR; end
            OP_LW:    begin reg_we = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; end
            OP_SW:    begin mem_we = 1'b1; use_imm = 1'b1; end
            OP_BEQ:   begin is_beq = 1'b1; alu_op = ALU_SUB; end
            OP_BNE:   begin is_bne = 1'b1; alu_op = ALU_SUB; end
            OP_J:     is_jmp = 1'b1;
            OP_HALT:  halt = HALT_EN;
            default:  ;
        endcase
    end

    // Register file reads are combinational. $0 is forced to zero.
    assign rs_data = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    assign rt_data = (rt == 5'd0) ? 32'h0 : regs_q[rt];
    assign wr_reg  = (opcode == OP_RTYPE) ? rd : rt;
    assign alu_b   = use_imm ? (imm_zext ? zimm : simm) : rt_data;

    // ALU. sll shifts rt by shamt. Branches reuse the subtract for their compare.
    always_comb begin
        alu_res = rs_data + alu_b;
        case (alu_op)
            ALU_SUB: alu_res = rs_data - alu_b;
            ALU_AND: alu_res = rs_data & alu_b;
            ALU_OR:  alu_res = rs_data | alu_b;
            ALU_XOR: alu_res = rs_data ^ alu_b;
            ALU_SLT: alu_res = {31'b0, $signed(rs_data) < $signed(alu_b)};
            ALU_SLL: alu_res = rt_data << shamt;
            default: ;
        endcase
    end

    // Data RAM read. The address wraps to the RAM size and is aligned to a word.
    // The word is assembled big-endian.
    assign daddr   = {alu_res[DAW-1:2], 2'b00};
    assign rd_word = {dmem_q[daddr], dmem_q[daddr | DAW'(1)],
                      dmem_q[daddr | DAW'(2)], dmem_q[daddr | DAW'(3)]};
    assign wr_data = mem_rd ? rd_word : alu_res;

    // Next-PC selection.
    assign pc4     = pc_q + 32'd4;
    assign br_tgt  = pc4 + {simm[29:0], 2'b00};
    assign take_br = (is_beq && alu_res == 32'h0) || (is_bne && alu_res != 32'h0);
    always_comb begin
        pc_d = pc4;
        if (halt)         pc_d = pc_q;
        else if (is_jmp)  pc_d = {pc4[31:28], instr[25:0], 2'b00};
        else if (take_br) pc_d = br_tgt;
    end

    // PC register.
    always_ff @(posedge CLK) begin
        if (Reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    // Register file write port. Writes to $0 are dropped.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (reg_we && wr_reg != 5'd0) begin
            regs_q[wr_reg] <= wr_data;
        end
    end

    // Data RAM write port. Reset clears the RAM, and sw stores rt big-endian.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
        end else if (mem_we) begin
            dmem_q[daddr]          <= rt_data[31:24];
            dmem_q[daddr | DAW'(1)] <= rt_data[23:16];
            dmem_q[daddr | DAW'(2)] <= rt_data[15:8];
            dmem_q[daddr | DAW'(3)] <= rt_data[7:0];
        end
    end

    assign dbg.cur_PC      = pc_q;
    assign dbg.new_PCaddr  = pc_d;
    assign dbg.ALU_Res     = alu_res;
    assign dbg.Write_Data  = wr_data;
    assign dbg.Data_rs     = rs_data;
    assign dbg.Data_rt     = rt_data;
    assign dbg.Instruction = instr;
    assign dbg.DataOut     = rd_word;
    assign dbg.Write_Reg   = wr_reg;
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core. It runs an ISA-level reference interpreter in parallel
// with the core, compares every exported node each cycle, and also checks hand-computed
// values at key instructions.
module tb_mips_single_cycle_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mips_single_cycle_core_if dbg ();

    mips_single_cycle_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(128), .IMEM_FILE("")) dut (
        .CLK(clk), .Reset(rst), .dbg(dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference interpreter state ----------------
    logic [31:0] prog [64];
    logic [31:0] mR [32];
    logic [7:0]  mM [128];
    logic [31:0] mPC = 0;

    logic [31:0] e_instr, e_npc, e_alu, e_wd, e_rs, e_rt, e_dout;
    logic [4:0]  e_wreg;
    bit          e_known, e_we, e_sw;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    // Evaluate the instruction at mPC against the model state. The model state is not modified.
    task model_eval;
        logic [31:0] s, z, a, b;
        logic [5:0]  op, fn;
        int base;
        e_instr = ((mPC >> 2) < 64) ? prog[int'(mPC >> 2)] : 32'h0;
        op = e_instr[31:26];
        fn = e_instr[5:0];
        a = (e_instr[25:21] == 0) ? 0 : mR[e_instr[25:21]];
        b = (e_instr[20:16] == 0) ? 0 : mR[e_instr[20:16]];
        s = 32'($signed(e_instr[15:0]));
        z = {16'h0, e_instr[15:0]};
        e_rs = a;
        e_rt = b;
        e_wreg = (op == 0) ? e_instr[15:11] : e_instr[20:16];
        e_known = 1; e_we = 0; e_sw = 0;
        e_alu = 0;
        e_npc = mPC + 4;
        case (op)
            6'h00: begin
                e_we = 1;
                case (fn)
                    6'h20: e_alu = a + b;
                    6'h22: e_alu = a - b;
                    6'h24: e_alu = a & b;
                    6'h25: e_alu = a | b;
                    6'h2A: e_alu = ($signed(a) < $signed(b)) ? 1 : 0;
                    6'h00: e_alu = b << e_instr[10:6];
                    default: begin e_we = 0; e_known = 0; end
                endcase
            end
            6'h09: begin e_we = 1; e_alu = a + s; end
            6'h0A: begin e_we = 1; e_alu = ($signed(a) < $signed(s)) ? 1 : 0; end
            6'h0C: begin e_we = 1; e_alu = a & z; end
            6'h0D: begin e_we = 1; e_alu = a | z; end
            6'h0E: begin e_we = 1; e_alu = a ^ z; end
            6'h23: begin e_we = 1; e_alu = a + s; end
            6'h2B: begin e_sw = 1; e_alu = a + s; end
            6'h04: begin e_alu = a - b; if (a == b) e_npc = mPC + 4 + (s << 2); end
            6'h05: begin e_alu = a - b; if (a != b) e_npc = mPC + 4 + (s << 2); end
            6'h02: begin e_known = 0; e_npc = {e_npc[31:28], e_instr[25:0], 2'b00}; end
`ifdef SCPU_HALT_EN
            6'h3F: begin e_known = 0; e_npc = mPC; end
`endif
            default: e_known = 0;
        endcase
        base = int'(e_alu % 128) & 124;
        e_dout = {mM[base], mM[base+1], mM[base+2], mM[base+3]};
        e_wd = (op == 6'h23) ? e_dout : e_alu;
    endtask

    // Advance the model by one edge.
    always @(posedge clk) begin
        if (rst) begin
            mPC = 0;
            for (int i = 0; i < 32; i++) mR[i] = 0;
            for (int i = 0; i < 128; i++) mM[i] = 0;
        end else begin
            model_eval();
            if (e_we && e_wreg != 0) mR[e_wreg] = e_wd;
            if (e_sw) begin
                int base;
                base = int'(e_alu % 128) & 124;
                mM[base] = e_rt[31:24]; mM[base+1] = e_rt[23:16];
                mM[base+2] = e_rt[15:8]; mM[base+3] = e_rt[7:0];
            end
            mPC = e_npc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    // Compare every exported node against the model on every checked cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            chk("cur_PC", dbg.cur_PC, mPC);
            chk("new_PCaddr", dbg.new_PCaddr, e_npc);
            chk("Instruction", dbg.Instruction, e_instr);
            chk("Data_rs", dbg.Data_rs, e_rs);
            chk("Data_rt", dbg.Data_rt, e_rt);
            chk("Write_Reg", {27'b0, dbg.Write_Reg}, {27'b0, e_wreg});
            if (e_known) begin
                chk("ALU_Res", dbg.ALU_Res, e_alu);
                chk("Write_Data", dbg.Write_Data, e_wd);
                chk("DataOut", dbg.DataOut, e_dout);
            end
        end
    end

    // Start at a negedge plus 1 time unit, and wait until cur_PC reaches addr.
    // Each step is bounded by the budget.
    task automatic wait_pc(input logic [31:0] addr, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (dbg.cur_PC === addr) break;
            @(negedge clk); #1;
        end
        chk("reach_pc", dbg.cur_PC, addr);
    endtask

    task automatic load(input logic [31:0] w [64]);
        for (int i = 0; i < 64; i++) begin
            prog[i] = w[i];
            dut.rom[i] = w[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
    endtask

    logic [31:0] pa [64];
    logic [31:0] pb [64];

    initial begin
        for (int i = 0; i < 64; i++) begin pa[i] = 0; pb[i] = 0; end
        pa[0]  = enc_i(6'h23, 0, 14, 4);       // lw   $14,4($0)
        pa[1]  = enc_i(6'h09, 0, 1, 8);        // addiu $1,$0,8
        pa[2]  = enc_i(6'h0D, 0, 2, 2);        // ori  $2,$0,2
        pa[3]  = enc_r(1, 2, 3, 0, 6'h20);     // add  $3,$1,$2
        pa[4]  = enc_i(6'h2B, 0, 3, 4);        // sw   $3,4($0)
        pa[5]  = enc_i(6'h23, 0, 4, 4);        // lw   $4,4($0)
        pa[6]  = enc_i(6'h09, 0, 0, 5);        // addiu $0,$0,5
        pa[7]  = enc_i(6'h09, 0, 1, 1);        // addiu $1,$0,1
        pa[8]  = enc_r(0, 1, 5, 0, 6'h22);     // sub  $5,$0,$1
        pa[9]  = enc_r(5, 1, 6, 0, 6'h2A);     // slt  $6,$5,$1
        pa[10] = enc_i(6'h0C, 5, 7, 16'hFFFF); // andi $7,$5,0xFFFF
        pa[11] = enc_r(4, 0, 8, 0, 6'h20);     // add  $8,$4,$0
        pa[12] = enc_i(6'h0E, 5, 10, 16'h00FF);// xori $10,$5,0xFF
        pa[13] = enc_i(6'h0A, 5, 11, 0);       // slti $11,$5,0
        pa[14] = enc_r(0, 1, 12, 4, 6'h00);    // sll  $12,$1,4
        pa[15] = enc_r(1, 1, 13, 0, 6'h3F);    // unknown funct
        pa[16] = enc_i(6'h2B, 0, 10, 8);       // sw   $10,8($0)
        pa[17] = enc_i(6'h23, 0, 15, 9);       // lw   $15,9($0)
        pa[18] = enc_i(6'h23, 0, 16, 16'h88);  // lw   $16,0x88($0)
        pa[19] = enc_j(6'h02, 16'h40);         // j    -> 0x100
        pb[0]  = enc_i(6'h09, 0, 1, 1);        // addiu $1,$0,1
        pb[1]  = enc_i(6'h05, 1, 1, 5);        // bne  $1,$1,5
        pb[2]  = enc_i(6'h05, 1, 0, 1);        // bne  $1,$0,1 (taken)
        pb[3]  = enc_j(6'h02, 16'h10);         // j    -> 0x40
        pb[4]  = enc_i(6'h04, 1, 1, -2);       // beq  $1,$1,-2
        pb[5]  = 32'hFC42FFFF;                 // opcode 111111
        pb[6]  = enc_i(6'h09, 0, 2, 7);        // addiu $2,$0,7
        pb[16] = enc_j(6'h02, 5);              // j    -> 0x14

        // Program A.
        load(pa);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; chk_en = 1'b1; #1;
        chk("rst_pc", dbg.cur_PC, 32'h0);
        chk("rst_rs", dbg.Data_rs, 32'h0);
        chk("rst_rt", dbg.Data_rt, 32'h0);
        chk("rst_npc", dbg.new_PCaddr, 32'h4);
        wait_pc(32'h0C, 20);
        chk("add_wreg", {27'b0, dbg.Write_Reg}, 32'd3);
        chk("add_alu", dbg.ALU_Res, 32'h0000000A);
        chk("add_wd", dbg.Write_Data, 32'h0000000A);
        wait_pc(32'h14, 20);
        chk("lw_alu", dbg.ALU_Res, 32'h4);
        chk("lw_dout", dbg.DataOut, 32'h0000000A);
        chk("lw_wreg", {27'b0, dbg.Write_Reg}, 32'd4);
        wait_pc(32'h1C, 20);
        chk("r0_zero", dbg.Data_rs, 32'h0);
        wait_pc(32'h20, 20);
        chk("sub_neg", dbg.ALU_Res, 32'hFFFFFFFF);
        wait_pc(32'h24, 20);
        chk("slt", dbg.ALU_Res, 32'h1);
        wait_pc(32'h28, 20);
        chk("andi", dbg.ALU_Res, 32'h0000FFFF);
        wait_pc(32'h2C, 20);
        chk("r4_read", dbg.Data_rs, 32'h0000000A);
        wait_pc(32'h34, 20);
        chk("slti", dbg.ALU_Res, 32'h1);
        wait_pc(32'h38, 20);
        chk("sll", dbg.ALU_Res, 32'h10);
        wait_pc(32'h44, 20);
        chk("lw_align", dbg.DataOut, 32'hFFFFFF00);
        wait_pc(32'h48, 20);
        chk("lw_wrap", dbg.DataOut, 32'hFFFFFF00);
        wait_pc(32'h4C, 20);
        chk("j_far", dbg.new_PCaddr, 32'h100);
        wait_pc(32'h100, 20);
        chk("rom_oob", dbg.Instruction, 32'h0);
        repeat (3) @(negedge clk);

        // Reset in the middle of the program also clears registers and RAM.
        do_reset();
        chk("rst2_pc", dbg.cur_PC, 32'h0);
        chk("rst2_rs", dbg.Data_rs, 32'h0);
        chk("rst2_rt", dbg.Data_rt, 32'h0);
        chk("rst2_npc", dbg.new_PCaddr, 32'h4);
        chk("rst2_ram", dbg.DataOut, 32'h0);
        wait_pc(32'h14, 20);
        chk("lw_again", dbg.DataOut, 32'h0000000A);

        // Program B: branches, jumps and opcode 111111.
        @(negedge clk); rst = 1'b1; chk_en = 1'b0;
        load(pb);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; chk_en = 1'b1; #1;
        wait_pc(32'h04, 20);
        chk("bne_nt", dbg.new_PCaddr, 32'h08);
        wait_pc(32'h08, 20);
        chk("bne_t", dbg.new_PCaddr, 32'h10);
        wait_pc(32'h10, 20);
        chk("beq_back", dbg.new_PCaddr, 32'h0C);
        chk("beq_alu", dbg.ALU_Res, 32'h0);
        wait_pc(32'h0C, 20);
        chk("j_0x10", dbg.new_PCaddr, 32'h40);
        wait_pc(32'h14, 20);
        @(negedge clk); #1;
`ifdef SCPU_HALT_EN
        chk("halt_1", dbg.cur_PC, 32'h14);
`else
        chk("nohalt_1", dbg.cur_PC, 32'h18);
`endif
        repeat (2) @(negedge clk); #1;
`ifdef SCPU_HALT_EN
        chk("halt_3", dbg.cur_PC, 32'h14);
`else
        chk("nohalt_3", dbg.cur_PC, 32'h20);
`endif
        do_reset();
        chk("rst3_pc", dbg.cur_PC, 32'h0);
        @(negedge clk); #1;
        chk("rst3_run", dbg.cur_PC, 32'h4);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
